// File: rtl/rat_arf_multi_pkg.sv
// Shared types for the rename table / architectural register file slice.
// Entry layout plus per-slot rename request/response bundles.
package rv32i_types;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int ROB_TAG_W  = 5;

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic                 busy;
        logic [ROB_TAG_W-1:0] tag;
    } rat_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [ROB_TAG_W-1:0]  rob_idx;
    } rename_req_t;

    typedef struct packed {
        logic                 ready;
        logic [XLEN-1:0]      data;
        logic [ROB_TAG_W-1:0] rob_idx;
    } rename_rsp_t;

endpackage

// File: rtl/rat_src_lookup.sv
// Single-source rename lookup: table read, older-slot forwarding, optional commit bypass.
// Purely combinational; RAT_COMMIT_BYPASS_EN adds same-cycle commit bypass.
module rat_src_lookup #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int SLOT           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_IDX_WIDTH  = 5,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic [ADDR_WIDTH-1:0]                  src_addr,
    input  logic [DATA_WIDTH-1:0]                  tbl_data,
    input  logic                                   tbl_busy,
    input  logic [ROB_IDX_WIDTH-1:0]               tbl_tag,
    input  logic [DISPATCH_WIDTH-1:0]              disp_valid,
    input  logic [DISPATCH_WIDTH*ADDR_WIDTH-1:0]   disp_rd_addr,
    input  logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] disp_rob_idx,
    input  logic [COMMIT_WIDTH-1:0]                commit_valid,
    input  logic [COMMIT_WIDTH*ADDR_WIDTH-1:0]     commit_rd_addr,
    input  logic [COMMIT_WIDTH*ROB_IDX_WIDTH-1:0]  commit_rob_idx,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]     commit_data,
    output logic                                   src_ready,
    output logic [DATA_WIDTH-1:0]                  src_data,
    output logic [ROB_IDX_WIDTH-1:0]               src_rob_idx
);

    logic fwd;

    always_comb begin
        fwd         = 1'b0;
        src_ready   = ~tbl_busy;
        src_data    = tbl_data;
        src_rob_idx = tbl_tag;

        // Later iterations win, so the youngest older producer supplies the tag.
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (i < SLOT && disp_valid[i] && src_addr != '0 &&
                disp_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == src_addr) begin
                fwd         = 1'b1;
                src_ready   = 1'b0;
                src_rob_idx = disp_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
            end
        end

`ifdef RAT_COMMIT_BYPASS_EN
        for (int p = 0; p < COMMIT_WIDTH; p++) begin
            if (!fwd && tbl_busy && commit_valid[p] && src_addr != '0 &&
                commit_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == src_addr &&
                commit_rob_idx[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tbl_tag) begin
                src_ready = 1'b1;
                src_data  = commit_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`endif

        if (src_addr == '0) begin
            src_ready   = 1'b1;
            src_data    = '0;
            src_rob_idx = '0;
        end
    end

    // Not every slot or build reads every input bit.
    logic unused_inputs;
    assign unused_inputs = ^{fwd, disp_valid, disp_rd_addr, disp_rob_idx,
                             commit_valid, commit_rd_addr, commit_rob_idx, commit_data};

endmodule

// File: rtl/rat_arf_multi.sv
// Multi-issue register alias table + architectural register file with flush recovery.
// Reads are zero-latency; renames/commits land at the next edge; RAT_COMMIT_BYPASS_EN enables commit bypass.
module rat_arf_multi
    import rv32i_types::*;
#(
    parameter int NUM_REGS       = rv32i_types::NUM_REGS,
    parameter int DATA_WIDTH     = rv32i_types::XLEN,
    parameter int ROB_IDX_WIDTH  = rv32i_types::ROB_TAG_W,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DISPATCH_WIDTH-1:0]               disp_valid,
    input  logic [DISPATCH_WIDTH*5-1:0]             disp_rs1_addr,
    input  logic [DISPATCH_WIDTH*5-1:0]             disp_rs2_addr,
    input  logic [DISPATCH_WIDTH*5-1:0]             disp_rd_addr,
    input  logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] disp_rob_idx,
    output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]    rs1_data,
    output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]    rs2_data,
    output logic [DISPATCH_WIDTH-1:0]               rs1_ready,
    output logic [DISPATCH_WIDTH-1:0]               rs2_ready,
    output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] rs1_rob_idx,
    output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] rs2_rob_idx,
    input  logic [COMMIT_WIDTH-1:0]                 commit_valid,
    input  logic [COMMIT_WIDTH*5-1:0]               commit_rd_addr,
    input  logic [COMMIT_WIDTH*ROB_IDX_WIDTH-1:0]   commit_rob_idx,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]      commit_data,
    input  logic                                    flush
);

    localparam int AW = REG_ADDR_W;

    rename_req_t req [DISPATCH_WIDTH];
    rat_entry_t  tbl_q [NUM_REGS];
    rat_entry_t  tbl_d [NUM_REGS];

    always_comb begin
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            req[s].valid   = disp_valid[s];
            req[s].rs1     = disp_rs1_addr[s*AW +: AW];
            req[s].rs2     = disp_rs2_addr[s*AW +: AW];
            req[s].rd      = disp_rd_addr[s*AW +: AW];
            req[s].rob_idx = disp_rob_idx[s*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
        end
    end

    // Order matters: commits first, then flush or dispatch, so a same-cycle
    // dispatch overrides a busy clear and later ports/slots override earlier ones.
    always_comb begin
        tbl_d = tbl_q;
        for (int p = 0; p < COMMIT_WIDTH; p++) begin
            if (commit_valid[p] && commit_rd_addr[p*AW +: AW] != '0) begin
                tbl_d[commit_rd_addr[p*AW +: AW]].data =
                    commit_data[p*DATA_WIDTH +: DATA_WIDTH];
                if (tbl_q[commit_rd_addr[p*AW +: AW]].tag ==
                    commit_rob_idx[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH])
                    tbl_d[commit_rd_addr[p*AW +: AW]].busy = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++)
                tbl_d[r].busy = 1'b0;
        end else begin
            for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                if (req[s].valid && req[s].rd != '0) begin
                    tbl_d[req[s].rd].busy = 1'b1;
                    tbl_d[req[s].rd].tag  = req[s].rob_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                tbl_q[r] <= '0;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : g_slot
        rename_rsp_t rsp1;
        rename_rsp_t rsp2;

        rat_src_lookup #(
            .DISPATCH_WIDTH (DISPATCH_WIDTH),
            .COMMIT_WIDTH   (COMMIT_WIDTH),
            .SLOT           (s),
            .DATA_WIDTH     (DATA_WIDTH),
            .ROB_IDX_WIDTH  (ROB_IDX_WIDTH),
            .ADDR_WIDTH     (AW)
        ) u_rs1 (
            .src_addr       (req[s].rs1),
            .tbl_data       (tbl_q[req[s].rs1].data),
            .tbl_busy       (tbl_q[req[s].rs1].busy),
            .tbl_tag        (tbl_q[req[s].rs1].tag),
            .disp_valid     (disp_valid),
            .disp_rd_addr   (disp_rd_addr),
            .disp_rob_idx   (disp_rob_idx),
            .commit_valid   (commit_valid),
            .commit_rd_addr (commit_rd_addr),
            .commit_rob_idx (commit_rob_idx),
            .commit_data    (commit_data),
            .src_ready      (rsp1.ready),
            .src_data       (rsp1.data),
            .src_rob_idx    (rsp1.rob_idx)
        );

        rat_src_lookup #(
            .DISPATCH_WIDTH (DISPATCH_WIDTH),
            .COMMIT_WIDTH   (COMMIT_WIDTH),
            .SLOT           (s),
            .DATA_WIDTH     (DATA_WIDTH),
            .ROB_IDX_WIDTH  (ROB_IDX_WIDTH),
            .ADDR_WIDTH     (AW)
        ) u_rs2 (
            .src_addr       (req[s].rs2),
            .tbl_data       (tbl_q[req[s].rs2].data),
            .tbl_busy       (tbl_q[req[s].rs2].busy),
            .tbl_tag        (tbl_q[req[s].rs2].tag),
            .disp_valid     (disp_valid),
            .disp_rd_addr   (disp_rd_addr),
            .disp_rob_idx   (disp_rob_idx),
            .commit_valid   (commit_valid),
            .commit_rd_addr (commit_rd_addr),
            .commit_rob_idx (commit_rob_idx),
            .commit_data    (commit_data),
            .src_ready      (rsp2.ready),
            .src_data       (rsp2.data),
            .src_rob_idx    (rsp2.rob_idx)
        );

        assign rs1_ready[s]                                  = rsp1.ready;
        assign rs1_data[s*DATA_WIDTH +: DATA_WIDTH]          = rsp1.data;
        assign rs1_rob_idx[s*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = rsp1.rob_idx;
        assign rs2_ready[s]                                  = rsp2.ready;
        assign rs2_data[s*DATA_WIDTH +: DATA_WIDTH]          = rsp2.data;
        assign rs2_rob_idx[s*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = rsp2.rob_idx;
    end

endmodule

// File: tb/tb_rat_arf_multi.sv
// Directed bench for rat_arf_multi: rename, forwarding, commit, flush and reset cases.
module tb_rat_arf_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  disp_valid;
    logic [9:0]  disp_rs1_addr, disp_rs2_addr, disp_rd_addr, disp_rob_idx;
    logic [63:0] rs1_data, rs2_data;
    logic [1:0]  rs1_ready, rs2_ready;
    logic [9:0]  rs1_rob_idx, rs2_rob_idx;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd_addr, commit_rob_idx;
    logic [63:0] commit_data;
    logic        flush;

    int n_chk  = 0;
    int n_fail = 0;

    rat_arf_multi dut (
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_rs1_addr  (disp_rs1_addr),
        .disp_rs2_addr  (disp_rs2_addr),
        .disp_rd_addr   (disp_rd_addr),
        .disp_rob_idx   (disp_rob_idx),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rs1_ready      (rs1_ready),
        .rs2_ready      (rs2_ready),
        .rs1_rob_idx    (rs1_rob_idx),
        .rs2_rob_idx    (rs2_rob_idx),
        .commit_valid   (commit_valid),
        .commit_rd_addr (commit_rd_addr),
        .commit_rob_idx (commit_rob_idx),
        .commit_data    (commit_data),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid   = '0;
        commit_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic dsp(input int s, input logic [4:0] rd, input logic [4:0] tag);
        disp_valid[s]          = 1'b1;
        disp_rd_addr[s*5 +: 5] = rd;
        disp_rob_idx[s*5 +: 5] = tag;
    endtask

    task automatic cmt(input int p, input logic [4:0] rd, input logic [4:0] tag,
                       input logic [31:0] dat);
        commit_valid[p]            = 1'b1;
        commit_rd_addr[p*5 +: 5]   = rd;
        commit_rob_idx[p*5 +: 5]   = tag;
        commit_data[p*32 +: 32]    = dat;
    endtask

    task automatic look(input int s, input logic [4:0] a, input string nm, input logic er,
                        input logic [31:0] ed, input logic [4:0] et, input bit cd);
        disp_rs1_addr[s*5 +: 5] = a;
        #1;
        chk({nm, "_rdy"}, 32'(rs1_ready[s]), 32'(er));
        if (cd) chk({nm, "_dat"}, rs1_data[s*32 +: 32], ed);
        chk({nm, "_tag"}, 32'(rs1_rob_idx[s*5 +: 5]), 32'(et));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        disp_rs1_addr = '0; disp_rs2_addr = '0; disp_rd_addr = '0; disp_rob_idx = '0;
        commit_rd_addr = '0; commit_rob_idx = '0; commit_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        look(0, 5'd5, "rst_x5_s0", 1'b1, 32'h0, 5'd0, 1'b1);
        look(1, 5'd5, "rst_x5_s1", 1'b1, 32'h0, 5'd0, 1'b1);
        look(0, 5'd0, "rst_x0_s0", 1'b1, 32'h0, 5'd0, 1'b1);
        disp_rs2_addr = {5'd5, 5'd0};
        #1;
        chk("rst_rs2_s1_rdy", 32'(rs2_ready[1]), 32'd1);
        chk("rst_rs2_s1_dat", rs2_data[63:32], 32'h0);
        chk("rst_rs2_s0_rdy", 32'(rs2_ready[0]), 32'd1);

        // Intra-bundle forwarding, then registered rename
        dsp(0, 5'd3, 5'd7);
        dsp(1, 5'd0, 5'd8);
        look(1, 5'd3, "fwd_x3_s1", 1'b0, 32'h0, 5'd7, 1'b0);
        look(0, 5'd3, "nofwd_x3_s0", 1'b1, 32'h0, 5'd0, 1'b1);
        tick(); idle();
        look(0, 5'd3, "ren_x3", 1'b0, 32'h0, 5'd7, 1'b0);

        // Stale commit writes data but keeps busy; matching commit frees it
        dsp(0, 5'd4, 5'd2); tick();
        dsp(0, 5'd4, 5'd9); tick(); idle();
        cmt(0, 5'd4, 5'd2, 32'hAA); tick(); idle();
        look(0, 5'd4, "stale_x4", 1'b0, 32'hAA, 5'd9, 1'b1);
        cmt(1, 5'd4, 5'd9, 32'hBB); tick(); idle();
        look(0, 5'd4, "done_x4", 1'b1, 32'hBB, 5'd9, 1'b1);

        // Same rd in both slots: slot 1 wins
        dsp(0, 5'd10, 5'd11);
        dsp(1, 5'd10, 5'd12);
        tick(); idle();
        look(1, 5'd10, "dup_x10", 1'b0, 32'h0, 5'd12, 1'b0);

        // Dispatch beats commit on busy/tag, commit still writes data
        dsp(0, 5'd6, 5'd1); tick(); idle();
        cmt(0, 5'd6, 5'd1, 32'h66);
        dsp(0, 5'd6, 5'd4);
        tick(); idle();
        look(0, 5'd6, "dvc_x6", 1'b0, 32'h66, 5'd4, 1'b1);

        // Flush with commit and dispatch in the same cycle
        dsp(0, 5'd1, 5'd3);
        dsp(1, 5'd2, 5'd5);
        tick(); idle();
        flush = 1'b1;
        cmt(0, 5'd1, 5'd3, 32'h11);
        dsp(0, 5'd8, 5'd13);
        tick(); idle();
        look(0, 5'd1, "fl_x1", 1'b1, 32'h11, 5'd3, 1'b1);
        look(0, 5'd2, "fl_x2", 1'b1, 32'h0, 5'd5, 1'b1);
        look(0, 5'd8, "fl_x8", 1'b1, 32'h0, 5'd0, 1'b1);
        look(1, 5'd10, "fl_x10", 1'b1, 32'h0, 5'd12, 1'b1);
        look(1, 5'd6, "fl_x6", 1'b1, 32'h66, 5'd4, 1'b1);

        // Two ports to one rd: port 1 data wins
        cmt(0, 5'd7, 5'd0, 32'h70);
        cmt(1, 5'd7, 5'd1, 32'h71);
        tick(); idle();
        look(0, 5'd7, "dup_cmt_x7", 1'b1, 32'h71, 5'd0, 1'b1);

        // Register 0 ignores writes and renames
        cmt(0, 5'd0, 5'd3, 32'hFF);
        dsp(0, 5'd0, 5'd3);
        tick(); idle();
        look(0, 5'd0, "x0_hard", 1'b1, 32'h0, 5'd0, 1'b1);

        // Commit visibility in the commit cycle and the next
        dsp(0, 5'd9, 5'd6); tick(); idle();
        cmt(0, 5'd9, 5'd6, 32'h55);
`ifdef RAT_COMMIT_BYPASS_EN
        look(0, 5'd9, "byp_x9_now", 1'b1, 32'h55, 5'd6, 1'b1);
`else
        look(0, 5'd9, "byp_x9_now", 1'b0, 32'h0, 5'd6, 1'b1);
`endif
        tick(); idle();
        look(0, 5'd9, "byp_x9_next", 1'b1, 32'h55, 5'd6, 1'b1);

        // Reset overrides concurrent dispatch, commit and flush
        rst = 1'b1;
        dsp(0, 5'd11, 5'd2);
        cmt(0, 5'd6, 5'd4, 32'h77);
        flush = 1'b1;
        tick(); idle();
        rst = 1'b0;
        look(0, 5'd6, "mrst_x6", 1'b1, 32'h0, 5'd0, 1'b1);
        look(0, 5'd11, "mrst_x11", 1'b1, 32'h0, 5'd0, 1'b1);
        look(1, 5'd2, "mrst_x2", 1'b1, 32'h0, 5'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_arf_multi.md
Name: rat_arf_multi

Overview:
- Parametrised register alias table plus architectural register file for a multi-issue out-of-order core.
- Sits between decode/dispatch and the ROB/reservation stations.
- Renames up to DISPATCH_WIDTH instructions per cycle, with intra-bundle dependency resolution.
- Retires up to COMMIT_WIDTH results per cycle into the ARF and restores committed state on flush.

Parameters:
NUM_REGS, 32, architectural registers; register 0 hardwired to zero.
DATA_WIDTH, 32, register data width.
ROB_IDX_WIDTH, 5, ROB tag width.
DISPATCH_WIDTH, 2, rename slots per cycle; slot 0 is oldest.
COMMIT_WIDTH, 2, commit ports per cycle; port 0 is oldest.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
disp_valid  in  DISPATCH_WIDTH  per-slot dispatch valid
disp_rs1_addr  in  DISPATCH_WIDTH*5  source 1 index per slot
disp_rs2_addr  in  DISPATCH_WIDTH*5  source 2 index per slot
disp_rd_addr  in  DISPATCH_WIDTH*5  destination index per slot
disp_rob_idx  in  DISPATCH_WIDTH*ROB_IDX_WIDTH  ROB tag allocated per slot
rs1_data / rs2_data  out  DISPATCH_WIDTH*DATA_WIDTH  ARF value of the source
rs1_ready / rs2_ready  out  DISPATCH_WIDTH  1 = value in the ARF is valid
rs1_rob_idx / rs2_rob_idx  out  DISPATCH_WIDTH*ROB_IDX_WIDTH  producer tag; valid when ready = 0
commit_valid  in  COMMIT_WIDTH  per-port commit
commit_rd_addr  in  COMMIT_WIDTH*5  committed destination
commit_rob_idx  in  COMMIT_WIDTH*ROB_IDX_WIDTH  committed tag
commit_data  in  COMMIT_WIDTH*DATA_WIDTH  committed value
flush  in  1  mispredict/exception recovery

Behaviour:
- State per register: data, busy, tag.
- Reset (rst high at a clk edge): all data = 0, busy = 0, tag = 0. On the first cycle after reset, every read returns ready = 1, data = 0, rob_idx = 0.
- Source reads are combinational from registered state, zero latency. For each source: ready = !busy, data = ARF data, rob_idx = tag.
- Intra-bundle forwarding: if slot j's source equals the rd of a valid slot i < j (rd != 0), the result is ready = 0 and rob_idx = the tag of the youngest such slot i. This overrides the table.
- Rename (takes effect at the next edge): for valid slots with rd != 0, set busy[rd] = 1 and tag[rd] = disp_rob_idx. If several slots share an rd, the highest slot index wins.
- Commit with rd != 0:
  - Always writes data[rd] = commit_data.
  - Clears busy[rd] only if tag[rd] == commit_rob_idx and no valid dispatch in the same cycle targets rd.
  - If several commit ports share an rd, the highest port wins for data. Busy clears if any port's tag matches, subject to the dispatch rule above.
- Dispatch vs commit on the same rd in the same cycle: dispatch wins for busy and tag; commit still writes data.
- Register 0: never busy, never written, reads always return data 0, ready 1.
- Flush:
  - On the next edge all busy = 0 and all tags are left unchanged.
  - Dispatch in the flush cycle is ignored.
  - Commits in the flush cycle still write data, since they are older than the flush.
- Reset asserted mid-operation overrides flush, dispatch and commit.
- No handshake: upstream guarantees ROB tags are unique while in flight.

Optional Feature:
RAT_COMMIT_BYPASS_EN
- Defined: a source read also matches same-cycle commits. If a commit port has addr == source (and source != 0) and commit_rob_idx == tag[source] while the register is busy, the read returns ready = 1 and data = commit_data, using the highest matching port. This bypass is suppressed when intra-bundle forwarding applies.
- Undefined: reads see registered state only, so a consumer sees ready one cycle after commit.

Decomposition:
- rv32i_types package: typedef rat_entry_t {data, busy, tag}, constant NUM_REGS, and the per-slot struct types rename_req_t and rename_rsp_t.
- Sub-module rat_src_lookup: a single-source combinational lookup covering the table, older-slot forwarding and optional bypass. It is instantiated 2*DISPATCH_WIDTH times.

Test Plan:
- Reset then read x5 and x0 from both slots -> ready = 1, data = 0, rob_idx = 0.
- Slot0 rd = x3 with tag 7, slot1 rs1 = x3 -> slot1 rs1_ready = 0, rs1_rob_idx = 7. Next cycle, a read of x3 -> ready = 0, rob_idx = 7.
- Dispatch x4 with tag 2, later x4 with tag 9, then commit x4 with tag 2 and data 0xAA -> data = 0xAA, busy stays 1, tag = 9. A later commit of tag 9 with data 0xBB -> ready = 1, data = 0xBB.
- Same cycle: commit x6 with tag 1 matching, and dispatch x6 with tag 4 -> x6 busy, tag 4, data = commit value.
- Rename x1 (tag 3) and x2 (tag 5), then assert flush together with commit x1 tag 3 data 0x11 and dispatch x8 -> all ready = 1, x1 = 0x11, x8 not busy.
- With RAT_COMMIT_BYPASS_EN: commit x9 with tag 6 data 0x55 while reading x9 -> ready = 1, data = 0x55 in the same cycle. Without it -> ready = 0, then ready = 1 the next cycle.
